// File: rtl/tilt_direction_decoder.sv
// Tilt direction decoder: averages four accelerometer samples per window, grades each axis
// into a speed level with downgrade hysteresis, and debounces the compass direction.
module tilt_direction_decoder #(
  parameter int unsigned T1         = 64,
  parameter int unsigned T2         = 256,
  parameter int unsigned T3         = 512,
  parameter int unsigned HYST       = 16,
  parameter int unsigned STABLE_CNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [11:0] accel_x,
  input  logic [11:0] accel_y,
  output logic [2:0]  ball_direction,
  output logic [1:0]  x_speed,
  output logic [1:0]  y_speed,
  output logic        dir_valid,
  output logic        sample_dropped
);

  localparam int CW = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {ACCUM, EVAL, UPDATE} state_t;

  state_t             state, state_next;
  logic signed [13:0] sum_x, sum_y;
  logic [1:0]         cnt;
  logic [2:0]         pending, pending_next;
  logic [CW-1:0]      stab_cnt, stab_cnt_next;
  logic [1:0]         x_speed_new, y_speed_new;
  logic [2:0]         dir_new;

  logic signed [11:0] avg_x, avg_y;
  logic [11:0]        mag_x, mag_y;
  logic [1:0]         x_speed_eval, y_speed_eval;
  logic [2:0]         cand, dir_eval;

  function automatic logic [1:0] level(input logic [13:0] m);
    if (m >= 14'(T3))      return 2'd3;
    else if (m >= 14'(T2)) return 2'd2;
    else if (m >= 14'(T1)) return 2'd1;
    else                   return 2'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= ACCUM;
    else      state <= state_next;
  end

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (sample_valid && cnt == 2'd3) state_next = EVAL;
        EVAL:    state_next = UPDATE;
        UPDATE:  state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  // Evaluation datapath; its results are captured at the end of the EVAL cycle.
  always_comb begin
    avg_x = 12'(sum_x >>> 2);
    avg_y = 12'(sum_y >>> 2);
    mag_x = avg_x[11] ? $unsigned(-avg_x) : $unsigned(avg_x);
    mag_y = avg_y[11] ? $unsigned(-avg_y) : $unsigned(avg_y);

    x_speed_eval = level(14'(mag_x));
    if (x_speed_eval < x_speed) x_speed_eval = level(14'(mag_x) + 14'(HYST));
    y_speed_eval = level(14'(mag_y));
    if (y_speed_eval < y_speed) y_speed_eval = level(14'(mag_y) + 14'(HYST));

    case ({x_speed_eval != 2'd0, y_speed_eval != 2'd0})
      2'b01:   cand = avg_y[11] ? 3'd4 : 3'd0;
      2'b10:   cand = avg_x[11] ? 3'd6 : 3'd2;
      2'b11: begin
        case ({avg_x[11], avg_y[11]})
          2'b00:   cand = 3'd1;
          2'b01:   cand = 3'd3;
          2'b11:   cand = 3'd5;
          default: cand = 3'd7;
        endcase
      end
      default: cand = ball_direction;
    endcase

    pending_next  = pending;
    stab_cnt_next = stab_cnt;
    dir_eval      = ball_direction;
    if (cand == ball_direction) begin
      stab_cnt_next = '0;
    end else if (cand == pending) begin
      stab_cnt_next = stab_cnt + 1'b1;
    end else begin
      pending_next  = cand;
      stab_cnt_next = CW'(1);
    end
    if (stab_cnt_next == CW'(STABLE_CNT)) begin
      dir_eval      = pending_next;
      stab_cnt_next = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_x          <= '0;
      sum_y          <= '0;
      cnt            <= '0;
      pending        <= '0;
      stab_cnt       <= '0;
      x_speed_new    <= '0;
      y_speed_new    <= '0;
      dir_new        <= '0;
      ball_direction <= '0;
      x_speed        <= '0;
      y_speed        <= '0;
      dir_valid      <= 1'b0;
      sample_dropped <= 1'b0;
    end else begin
      dir_valid <= 1'b0;
      if (!enable) begin
        sum_x    <= '0;
        sum_y    <= '0;
        cnt      <= '0;
        stab_cnt <= '0;
        x_speed  <= '0;
        y_speed  <= '0;
      end else begin
        if (sample_valid && state != ACCUM) sample_dropped <= 1'b1;
        case (state)
          ACCUM: begin
            if (sample_valid) begin
              sum_x <= sum_x + $signed({{2{accel_x[11]}}, accel_x});
              sum_y <= sum_y + $signed({{2{accel_y[11]}}, accel_y});
              cnt   <= cnt + 2'd1;
            end
          end
          EVAL: begin
            x_speed_new <= x_speed_eval;
            y_speed_new <= y_speed_eval;
            dir_new     <= dir_eval;
            pending     <= pending_next;
            stab_cnt    <= stab_cnt_next;
          end
          UPDATE: begin
            x_speed        <= x_speed_new;
            y_speed        <= y_speed_new;
            ball_direction <= dir_new;
            dir_valid      <= 1'b1;
            sum_x          <= '0;
            sum_y          <= '0;
            cnt            <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tilt_direction_decoder.sv
// Directed bench for tilt_direction_decoder: hand-computed speed/direction per window,
// latency, hysteresis, debounce, dropped samples, reset and enable behaviour.
module tb_tilt_direction_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] accel_x = '0;
  logic [11:0] accel_y = '0;
  logic [2:0]  ball_direction;
  logic [1:0]  x_speed, y_speed;
  logic        dir_valid, sample_dropped;

  int n_vec = 0;
  int n_bad = 0;

  tilt_direction_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .sample_valid   (sample_valid),
    .accel_x        (accel_x),
    .accel_y        (accel_y),
    .ball_direction (ball_direction),
    .x_speed        (x_speed),
    .y_speed        (y_speed),
    .dir_valid      (dir_valid),
    .sample_dropped (sample_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int x, input int y);
    @(negedge clk);
    sample_valid = 1'b1;
    accel_x      = 12'(x);
    accel_y      = 12'(y);
  endtask

  // Counts negedges from the one right after the 4th-sample edge until dir_valid shows.
  task automatic wait_update(input string tag, input int exp_lat);
    int k;
    @(negedge clk);
    sample_valid = 1'b0;
    k = 0;
    while (!dir_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, exp_lat);
    @(negedge clk);
    check({tag, "_pulse"}, int'(dir_valid), 0);
  endtask

  task automatic expect_out(input string tag, input int xs, input int ys, input int dir);
    check({tag, "_xs"}, int'(x_speed), xs);
    check({tag, "_ys"}, int'(y_speed), ys);
    check({tag, "_dir"}, int'(ball_direction), dir);
  endtask

  task automatic window(input string tag, input int x, input int y);
    repeat (4) push(x, y);
    wait_update(tag, 2);
  endtask

  initial begin
    int seen;

    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0);
    check("reset_dv", int'(dir_valid), 0);
    check("reset_sd", int'(sample_dropped), 0);
    rst    = 1'b1;
    enable = 1'b1;

    // Steady east tilt: speed on the first window, direction only after the second.
    window("east1", 300, 0);
    expect_out("east1", 2, 0, 0);
    window("east2", 300, 0);
    expect_out("east2", 2, 0, 2);

    // Downgrade hysteresis from FAST.
    window("fast", 600, 0);
    expect_out("fast", 3, 0, 2);
    window("hyst_hold", 500, 0);
    expect_out("hyst_hold", 3, 0, 2);
    window("hyst_drop", 490, 0);
    expect_out("hyst_drop", 2, 0, 2);

    // North-west, then a small negative average that must shift arithmetically.
    window("nw1", -100, 700);
    expect_out("nw1", 1, 3, 2);
    window("nw2", -100, 700);
    expect_out("nw2", 1, 3, 7);
    push(-1, 0);
    push(-2, 0);
    push(-3, 0);
    push(-2, 0);
    wait_update("small_neg", 2);
    expect_out("small_neg", 0, 0, 7);

    // Reach south, then alternate E and N: the debounce never settles.
    window("s1", 0, -300);
    expect_out("s1", 0, 2, 7);
    window("s2", 0, -300);
    expect_out("s2", 0, 2, 4);
    window("alt_e1", 300, 0);
    expect_out("alt_e1", 2, 0, 4);
    window("alt_n1", 0, 300);
    expect_out("alt_n1", 0, 2, 4);
    window("alt_e2", 300, 0);
    expect_out("alt_e2", 2, 0, 4);
    window("alt_n2", 0, 300);
    expect_out("alt_n2", 0, 2, 4);

    // Sample held into the EVAL cycle is dropped and not counted toward the next window.
    repeat (4) push(300, 0);
    push(300, 0);
    wait_update("drop_win", 1);
    check("drop_sd", int'(sample_dropped), 1);
    expect_out("drop_win", 2, 0, 4);
    repeat (3) push(300, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      if (dir_valid) seen = 1;
      @(negedge clk);
    end
    check("drop_no_early_dv", seen, 0);
    push(300, 0);
    wait_update("drop_next", 2);
    expect_out("drop_next", 2, 0, 2);

    // Reset mid-window discards the partial sums.
    repeat (3) push(70, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_out("midrst", 0, 0, 0);
    check("midrst_dv", int'(dir_valid), 0);
    check("midrst_sd", int'(sample_dropped), 0);
    window("post_rst", 70, 0);
    expect_out("post_rst", 1, 0, 0);
    window("post_rst2", 70, 0);
    expect_out("post_rst2", 1, 0, 2);

    // Enable low (with a coincident sample) idles speeds, holds direction, clears the window.
    push(300, 0);
    push(300, 0);
    @(negedge clk);
    enable       = 1'b0;
    sample_valid = 1'b1;
    @(negedge clk);
    enable       = 1'b1;
    sample_valid = 1'b0;
    expect_out("disable", 0, 0, 2);
    check("disable_dv", int'(dir_valid), 0);
    check("disable_sd", int'(sample_dropped), 0);
    window("reenable", 300, 0);
    expect_out("reenable", 2, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
